// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - assembles little-endian UART bytes into 32-bit words and writes them to instruction memory
module uart_imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] TERM_WORD = 32'hFFFFFFFF,
  parameter int          TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count,
  output logic              err_break,
  output logic              err_timeout
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic [TW-1:0]     tcnt;
  logic              is_term;
  logic              mem_full;
  logic              do_write;

  assign is_term  = (word_q == TERM_WORD);
  assign mem_full = (wr_ptr == {ADDR_W{1'b1}});
  // Gated by rst so a WRITE interrupted by reset never reaches memory.
  assign do_write = (state == S_WRITE) && !is_term && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (load_en) state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (rx_break)                          state_nxt = S_ERROR;
        else if (rx_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (rx_break)                 state_nxt = S_ERROR;
        else if (is_term || mem_full) state_nxt = S_DONE;
        else                          state_nxt = S_COLLECT;
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERROR: state_nxt = S_ERROR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word_q      <= '0;
      byte_idx    <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      tcnt        <= '0;
      err_break   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_COLLECT: begin
          if (rx_break) begin
            byte_idx  <= '0;
            word_q    <= '0;
            tcnt      <= '0;
            err_break <= 1'b1;
          end else if (rx_valid) begin
            word_q[8*byte_idx +: 8] <= rx_data;
            byte_idx                <= byte_idx + 2'd1;
            tcnt                    <= '0;
          end else if (byte_idx != 2'd0) begin
            if (tcnt == TCNT_LAST) begin
              byte_idx    <= '0;
              word_q      <= '0;
              tcnt        <= '0;
              err_timeout <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else begin
            tcnt <= '0;
          end
        end
        S_WRITE: begin
          tcnt <= '0;
          if (do_write) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count_q <= count_q + 1'b1;
          end
          if (rx_break) begin
            err_break <= 1'b1;
          end else if (rx_valid && !is_term && !mem_full) begin
            // A byte landing during the write cycle starts the next word.
            word_q[7:0] <= rx_data;
            byte_idx    <= 2'd1;
          end
        end
        default: begin
          tcnt <= '0;
        end
      endcase
    end
  end

  assign imem_we    = do_write;
  assign imem_addr  = wr_ptr;
  assign imem_wdata = word_q;
  assign word_count = count_q;
  assign write_done = (state == S_DONE) && !rst;
  assign cpu_rst    = (state != S_DONE) || rst;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - directed self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

  localparam int          ADDR_W  = 2;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] TERM    = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              write_done;
  logic              cpu_rst;
  logic [ADDR_W:0]   word_count;
  logic              err_break;
  logic              err_timeout;

  int n_checks = 0;
  int n_err    = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];

  uart_imem_loader #(
    .ADDR_W   (ADDR_W),
    .TERM_WORD(TERM),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .write_done (write_done),
    .cpu_rst    (cpu_rst),
    .word_count (word_count),
    .err_break  (err_break),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic arm();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
  endtask

  task automatic check_wr(input int i, input int addr, input logic [31:0] data);
    if (i < wr_data.size()) begin
      check($sformatf("wr%0d_addr", i), 64'(wr_addr[i]), 64'(addr));
      check($sformatf("wr%0d_data", i), 64'(wr_data[i]), 64'(data));
    end else begin
      check($sformatf("wr%0d_missing", i), 64'(wr_data.size()), 64'(i + 1));
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    load_en  = 1'b0;
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    check("rst_we",    64'(imem_we),     64'd0);
    check("rst_addr",  64'(imem_addr),   64'd0);
    check("rst_wdata", 64'(imem_wdata),  64'd0);
    check("rst_done",  64'(write_done),  64'd0);
    check("rst_cpu",   64'(cpu_rst),     64'd1);
    check("rst_count", 64'(word_count),  64'd0);
    check("rst_ebrk",  64'(err_break),   64'd0);
    check("rst_etmo",  64'(err_timeout), 64'd0);
  endtask

  initial begin
    do_reset();

    // Single word then terminator; a byte in IDLE must be ignored.
    send_byte(8'hAA);
    arm();
    send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFD);
    @(negedge clk);
    check("lat_we",    64'(imem_we),    64'd1);
    check("lat_addr",  64'(imem_addr),  64'd0);
    check("lat_wdata", 64'(imem_wdata), 64'hFD010113);
    tick();
    send_word(TERM);
    tick(); tick();
    check("w1_nwr",   64'(wr_data.size()), 64'd1);
    check_wr(0, 0, 32'hFD010113);
    check("w1_done",  64'(write_done), 64'd1);
    check("w1_cpu",   64'(cpu_rst),    64'd0);
    check("w1_count", 64'(word_count), 64'd1);
    rx_break = 1'b1; tick(); rx_break = 1'b0;
    send_word(32'h01020304);
    tick();
    check("done_ebrk", 64'(err_break),       64'd0);
    check("done_hold", 64'(write_done),      64'd1);
    check("done_nwr",  64'(wr_data.size()),  64'd1);

    // Three back-to-back words: bytes land in WRITE cycles.
    do_reset();
    arm();
    send_word(32'h02812623);
    send_word(32'h03010413);
    send_word(32'hFE042623);
    send_word(TERM);
    tick(); tick();
    check("w3_nwr", 64'(wr_data.size()), 64'd3);
    check_wr(0, 0, 32'h02812623);
    check_wr(1, 1, 32'h03010413);
    check_wr(2, 2, 32'hFE042623);
    check("w3_count", 64'(word_count), 64'd3);
    check("w3_done",  64'(write_done), 64'd1);

    // Memory full at 4 words; 5th ignored.
    do_reset();
    arm();
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    send_word(32'h55555555);
    tick(); tick();
    check("full_nwr", 64'(wr_data.size()), 64'd4);
    check_wr(3, 3, 32'h44444444);
    check("full_count", 64'(word_count), 64'd4);
    check("full_done",  64'(write_done), 64'd1);

    // Timeout discards a partial word at exactly TIMEOUT idle cycles.
    do_reset();
    arm();
    send_byte(8'hEE); send_byte(8'hDD);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("tmo_early", 64'(err_timeout), 64'd0);
    tick();
    check("tmo_set", 64'(err_timeout), 64'd1);
    send_word(32'h44332211);
    tick();
    send_word(TERM);
    tick(); tick();
    check("tmo_nwr", 64'(wr_data.size()), 64'd1);
    check_wr(0, 0, 32'h44332211);
    check("tmo_done", 64'(write_done), 64'd1);

    // Break mid-word aborts into ERROR; a simultaneous byte is dropped.
    do_reset();
    arm();
    send_byte(8'h01); send_byte(8'h02);
    rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h03;
    tick();
    rx_break = 1'b0; rx_valid = 1'b0;
    check("brk_ebrk", 64'(err_break),  64'd1);
    check("brk_cpu",  64'(cpu_rst),    64'd1);
    check("brk_done", 64'(write_done), 64'd0);
    send_word(32'h12345678);
    send_word(TERM);
    tick();
    check("brk_nwr",   64'(wr_data.size()), 64'd0);
    check("brk_done2", 64'(write_done),     64'd0);

    // Reset mid-word leaves no stale bytes.
    do_reset();
    arm();
    send_byte(8'h99); send_byte(8'h88); send_byte(8'h77);
    do_reset();
    arm();
    send_word(32'hAABBCCDD);
    send_word(TERM);
    tick(); tick();
    check("rw_nwr", 64'(wr_data.size()), 64'd1);
    check_wr(0, 0, 32'hAABBCCDD);
    check("rw_count", 64'(word_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 Parameter TERM_WORD, 32'hFFFFFFFF, end-of-program marker word; never written to memory.
REQ-003 Parameter TIMEOUT, 50000, idle cycles allowed between bytes of one partial word.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  arms the loader from IDLE.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
REQ-008 rx_data  input  8  received UART byte.
REQ-009 rx_break  input  1  one-cycle strobe; BREAK detected on the line.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  ADDR_W  word address for the write.
REQ-012 imem_wdata  output  32  word to write.
REQ-013 write_done  output  1  program load complete; sticky until rst.
REQ-014 cpu_rst  output  1  holds the core in reset while not DONE.
REQ-015 word_count  output  ADDR_W+1  number of words written.
REQ-016 err_break  output  1  sticky; load aborted by BREAK.
REQ-017 err_timeout  output  1  sticky; at least one partial word discarded on timeout.

Function
REQ-018 The block SHALL implement states IDLE, COLLECT, WRITE, DONE, ERROR.
REQ-019 IDLE: load_en=1 -> COLLECT next cycle; rx_valid ignored in IDLE.
REQ-020 COLLECT: each rx_valid stores rx_data at byte lane byte_idx (little-endian: first byte -> bits [7:0]), byte_idx increments 0..3.
REQ-021 On the 4th byte the block SHALL enter WRITE next cycle with the assembled word held in imem_wdata.
REQ-022 WRITE, word != TERM_WORD: imem_we=1 for exactly one cycle, imem_addr=write pointer; pointer and word_count increment the following cycle; return to COLLECT.
REQ-023 WRITE, word == TERM_WORD: no write; -> DONE.
REQ-024 WRITE of address 2^ADDR_W-1 (memory full): write performed, then -> DONE; further bytes ignored.
REQ-025 rx_valid arriving in the WRITE cycle SHALL be captured as byte 0 of the next word (no byte lost).
REQ-026 Latency: imem_we asserts exactly 1 cycle after the rx_valid of the 4th byte.
REQ-027 Timeout: in COLLECT with byte_idx!=0, a counter increments each cycle without rx_valid and clears on rx_valid; on reaching TIMEOUT, partial word discarded, byte_idx=0, err_timeout=1, state stays COLLECT.
REQ-028 rx_break in COLLECT or WRITE -> ERROR (a WRITE-cycle write still completes); partial word discarded; err_break=1.
REQ-029 rx_break and rx_valid in the same cycle: break wins, byte discarded.
REQ-030 DONE: write_done=1, cpu_rst=0, all inputs except rst ignored.
REQ-031 ERROR: cpu_rst=1, write_done=0; exits only via rst.
REQ-032 load_en deassertion after leaving IDLE SHALL have no effect.
REQ-033 cpu_rst SHALL be 1 in every state except DONE.

Reset
REQ-034 rst=1 at a clock edge SHALL from any state, including mid-word or mid-WRITE, force IDLE, imem_we=0, imem_addr=0, imem_wdata=0, write_done=0, cpu_rst=1, word_count=0, err_break=0, err_timeout=0, byte_idx=0, pointer=0, timeout counter=0.
REQ-035 rst SHALL override all other inputs in the same cycle; no write issues in the reset cycle.

Verification
REQ-036 load_en, bytes 13 01 01 FD then FF FF FF FF -> one write addr 0 data 32'hFD010113; write_done=1, cpu_rst=0, word_count=1.
REQ-037 Three words 32'h02812623, 32'h03010413, 32'hFE042623 then TERM -> writes at addr 0,1,2 in order; word_count=3.
REQ-038 ADDR_W=2, five words without TERM -> writes at addr 0..3 only; DONE after 4th; 5th ignored; word_count=4.
REQ-039 Two bytes then TIMEOUT idle cycles, then bytes 11 22 33 44 -> err_timeout=1, one write data 32'h44332211 addr 0.
REQ-040 rx_break after 2 bytes of word 1 -> ERROR, err_break=1, cpu_rst=1, no write, write_done=0.
REQ-041 rst asserted after 3 bytes, then full word 32'hAABBCCDD plus TERM -> write at addr 0 with 32'hAABBCCDD; no stale bytes.
